peak_mean_extractor: RTL and testbench

Multi-channel, mode-selectable successor to the single-channel mean-amplitude feature extractor in the HDC seizure-detection feature front end. For each of NUM_CHS channels it scans one window of signed samples and finds local peaks (mode 0) or local troughs (mode 1). It averages the peak values and quantises the mean into NUM_LEVELS levels for the item-memory lookup. Channels are processed sequentially under a start/busy/done handshake, and windows with no peaks are flagged per channel.

---
 rtl/peak_mean_extractor.sv | 132 +++++++++++++
 tb/tb_peak_mean_extractor.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/peak_mean_extractor.sv
// rtl/peak_mean_extractor.sv - multi-channel peak/trough mean extractor with level quantisation
// Scans each channel window for local extrema, averages them and maps the mean onto NUM_LEVELS.
module peak_mean_extractor #(
    parameter int NUM_CHS     = 17,
    parameter int WINDOW_SIZE = 256,
    parameter int SAMPLE_SIZE = 16,
    parameter int NUM_LEVELS  = 64,
    parameter logic signed [SAMPLE_SIZE-1:0] MIN_VAL = 16'shF782,
    parameter logic signed [SAMPLE_SIZE-1:0] MAX_VAL = 16'sh09AA
) (
    input  logic                                                 clk,
    input  logic                                                 nrst,
    input  logic                                                 en,
    input  logic                                                 mode,
    input  logic [NUM_CHS-1:0][WINDOW_SIZE-1:0][SAMPLE_SIZE-1:0] samples,
    output logic                                                 busy,
    output logic                                                 done,
    output logic [NUM_CHS-1:0][$clog2(NUM_LEVELS)-1:0]           level,
    output logic [NUM_CHS-1:0]                                   no_peak
);
    localparam int LW   = $clog2(NUM_LEVELS);
    localparam int CW   = $clog2(WINDOW_SIZE);
    localparam int SW   = SAMPLE_SIZE + CW;
    localparam int CHW  = (NUM_CHS > 1) ? $clog2(NUM_CHS) : 1;
    localparam int STEP = (int'(MIN_VAL) > int'(MAX_VAL)) ? 1 : ((int'(MAX_VAL) - int'(MIN_VAL)) >> LW);

    localparam logic signed [SW-1:0] MIN_EXT = {{CW{MIN_VAL[SAMPLE_SIZE-1]}}, MIN_VAL};
    localparam logic signed [SW-1:0] MAX_EXT = {{CW{MAX_VAL[SAMPLE_SIZE-1]}}, MAX_VAL};

    typedef enum logic [1:0] {IDLE, SCAN, DIV, QUANT} state_t;

    state_t                 state;
    logic [CHW-1:0]         ch;
    logic [CW-1:0]          idx;
    logic signed [SW-1:0]   sum;
    logic signed [SW-1:0]   mean;
    logic [CW-1:0]          cnt;
    logic                   mode_q;

    logic signed [SAMPLE_SIZE-1:0] s_l, s_c, s_r;
    logic                          is_peak;
    logic [SW-1:0]                 diff2;
    logic [SW-1:0]                 q;
    logic [SW-1:0]                 lvl_raw;
    logic [LW-1:0]                 lvl_next;

    assign s_l = $signed(samples[ch][idx - 1'b1]);
    assign s_c = $signed(samples[ch][idx]);
    assign s_r = $signed(samples[ch][idx + 1'b1]);

    // Non-strict comparisons so that plateaus count as extrema.
    assign is_peak = mode_q ? ((s_l >= s_c) && (s_c <= s_r))
                            : ((s_l <= s_c) && (s_c >= s_r));

    // Doubling before the divide gives one fractional bit for round-half-up.
    always_comb begin
        diff2    = (mean - MIN_EXT) <<< 1;
        q        = diff2 / SW'(STEP);
        lvl_raw  = (q >> 1) + {{(SW-1){1'b0}}, q[0]};
        lvl_next = '0;
        if (cnt == '0 || mean < MIN_EXT)
            lvl_next = '0;
        else if (mean > MAX_EXT || lvl_raw > SW'(NUM_LEVELS - 1))
            lvl_next = LW'(NUM_LEVELS - 1);
        else
            lvl_next = lvl_raw[LW-1:0];
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            level   <= '0;
            no_peak <= '0;
            ch      <= '0;
            idx     <= CW'(1);
            sum     <= '0;
            mean    <= '0;
            cnt     <= '0;
            mode_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (en) begin
                        mode_q <= mode;
                        ch     <= '0;
                        idx    <= CW'(1);
                        sum    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (is_peak) begin
                        sum <= sum + {{CW{s_c[SAMPLE_SIZE-1]}}, s_c};
                        cnt <= cnt + 1'b1;
                    end
                    if (idx == CW'(WINDOW_SIZE - 2))
                        state <= DIV;
                    else
                        idx <= idx + 1'b1;
                end
                DIV: begin
                    if (cnt == '0)
                        mean <= '0;
                    else
                        mean <= sum / $signed({{(SW-CW){1'b0}}, cnt});
                    state <= QUANT;
                end
                QUANT: begin
                    level[ch]   <= lvl_next;
                    no_peak[ch] <= (cnt == '0);
                    if (ch == CHW'(NUM_CHS - 1)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        ch    <= ch + 1'b1;
                        idx   <= CW'(1);
                        sum   <= '0;
                        cnt   <= '0;
                        state <= SCAN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_peak_mean_extractor.sv
// tb/tb_peak_mean_extractor.sv - directed self-checking bench for peak_mean_extractor
module tb_peak_mean_extractor;
    localparam int NCH = 17;
    localparam int WS  = 256;
    localparam int RUN = NCH * WS;

    logic                          clk = 1'b0;
    logic                          nrst;
    logic                          en;
    logic                          mode;
    logic [NCH-1:0][WS-1:0][15:0]  samples;
    logic                          busy;
    logic                          done;
    logic [NCH-1:0][5:0]           level;
    logic [NCH-1:0]                no_peak;

    int n_pass = 0;
    int n_total = 0;

    peak_mean_extractor dut (
        .clk(clk), .nrst(nrst), .en(en), .mode(mode), .samples(samples),
        .busy(busy), .done(done), .level(level), .no_peak(no_peak)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   kind;     // 0 ramp, 1 constant, 2 alternating +val/-val
        int   val;
        logic m;
        int   exp_lvl;
        logic exp_np;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic fill(input int kind, input int val);
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < WS; i++)
                case (kind)
                    0: samples[c][i] = 16'(i);
                    1: samples[c][i] = 16'(val);
                    default: samples[c][i] = (i % 2 == 0) ? 16'(val) : 16'(-val);
                endcase
    endtask

    // Called #1 after a rising edge with the DUT idle; returns edges from start to done.
    task automatic start_and_wait(input logic m, output int n);
        mode = m;
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        n = 0;
        while (!done && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    function automatic int model_level(input int mean);
        int q;
        if (mean < -2174) return 0;
        if (mean > 2474) return 63;
        q = (2 * (mean + 2174)) / 72;
        q = (q >> 1) + (q & 1);
        return (q > 63) ? 63 : q;
    endfunction

    task automatic check_all(input string tag, input int lv, input int np);
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("%s_level_ch%0d", tag, c), int'(level[c]), lv);
            chk($sformatf("%s_nopeak_ch%0d", tag, c), int'(no_peak[c]), np);
        end
    endtask

    initial begin
        int n, n2;
        int first_chg[NCH];
        int exp_lv[NCH];

        vecs[0] = '{0, 0,     1'b0, 0,  1'b1};
        vecs[1] = '{1, 0,     1'b0, 30, 1'b0};
        vecs[2] = '{1, 0,     1'b1, 30, 1'b0};
        vecs[3] = '{1, -2175, 1'b0, 0,  1'b0};
        vecs[4] = '{1, 2475,  1'b0, 63, 1'b0};
        vecs[5] = '{2, 1000,  1'b0, 44, 1'b0};
        vecs[6] = '{2, 1000,  1'b1, 16, 1'b0};
        vecs[7] = '{1, 2474,  1'b0, 63, 1'b0};
        vecs[8] = '{1, -2174, 1'b0, 0,  1'b0};
        vecs[9] = '{1, -2138, 1'b0, 1,  1'b0};

        nrst = 1'b0; en = 1'b0; mode = 1'b0;
        fill(1, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_level", int'(level), 0);
        chk("reset_nopeak", int'(no_peak), 0);
        nrst = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 10; v++) begin
            fill(vecs[v].kind, vecs[v].val);
            start_and_wait(vecs[v].m, n);
            chk($sformatf("v%0d_done_latency", v), n, RUN);
            chk($sformatf("v%0d_busy_at_done", v), int'(busy), 0);
            check_all($sformatf("v%0d", v), vecs[v].exp_lvl, int'(vecs[v].exp_np));
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", v), int'(done), 0);
        end

        // mode toggling and en pulses while busy must not disturb the run
        fill(2, 1000);
        mode = 1'b0; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        n = 0;
        while (!done && n < 5000) begin
            if (n % 100 == 50) mode = ~mode;
            en = (n % 333 == 7);
            @(posedge clk); #1;
            n++;
        end
        en = 1'b0;
        chk("toggle_done_latency", n, RUN);
        check_all("toggle", 44, 0);
        @(posedge clk); #1;

        // per-channel distinct values: each level lands exactly on its QUANT edge
        for (int c = 0; c < NCH; c++) begin
            for (int i = 0; i < WS; i++) samples[c][i] = 16'(50 * c - 400);
            exp_lv[c] = model_level(50 * c - 400);
            first_chg[c] = -1;
        end
        mode = 1'b0; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        n = 0;
        while (!done && n < 5000) begin
            @(posedge clk); #1;
            n++;
            for (int c = 0; c < NCH; c++)
                if (first_chg[c] < 0 && int'(level[c]) == exp_lv[c]) first_chg[c] = n;
            if (n == RUN - 1) begin
                chk("perch_busy_before_done", int'(busy), 1);
                chk("perch_done_before_end", int'(done), 0);
            end
        end
        chk("perch_done_latency", n, RUN);
        chk("perch_busy_with_done", int'(busy), 0);
        for (int c = 0; c < NCH; c++)
            chk($sformatf("perch_update_edge_ch%0d", c), first_chg[c], (c + 1) * WS);
        @(posedge clk); #1;
        chk("perch_done_pulse", int'(done), 0);

        // asynchronous reset during channel 1
        fill(1, 1000);
        mode = 1'b0; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        chk("mid_level0_before_reset", int'(level[0]), 44);
        nrst = 1'b0;
        #1;
        chk("mid_reset_busy", int'(busy), 0);
        chk("mid_reset_done", int'(done), 0);
        chk("mid_reset_level", int'(level), 0);
        chk("mid_reset_nopeak", int'(no_peak), 0);
        n2 = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done) n2++;
        end
        nrst = 1'b1;
        n = 0;
        while (!done && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mid_no_done_after_reset", n2 + int'(done), 0);
        start_and_wait(1'b0, n);
        chk("mid_rerun_latency", n, RUN);
        check_all("mid_rerun", 44, 0);
        @(posedge clk); #1;

        // en held high: back-to-back runs every RUN+1 cycles
        fill(1, 0);
        mode = 1'b0; en = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!done && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("held_first_latency", n, RUN);
        n2 = 0;
        do begin
            @(posedge clk); #1;
            n2++;
        end while (!done && n2 < 5000);
        en = 1'b0;
        chk("held_second_interval", n2, RUN + 1);
        check_all("held", 30, 0);
        @(posedge clk); #1;
        chk("held_idle_after_release", int'(busy), 0);
        chk("held_done_pulse", int'(done), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
